// File: rtl/vga_value_display_pkg.sv
// Shared types and helpers for the VGA value overlay: FSM states, ASCII
// codes, active-video limits and a segment-style glyph renderer used for
// the label, colon, sign and digit cells.
package vga_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CONV   = 3'd2,
    ST_STORE  = 3'd3,
    ST_COMMIT = 3'd4
  } disp_state_t;

  localparam logic [7:0] ASC_X     = 8'h58;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_0     = 8'h30;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // Segment set {a,b,c,d,e,f,g} for each supported character.
  function automatic logic [6:0] seg_of(input logic [7:0] code);
    case (code)
      8'h30:   seg_of = 7'b1111110;
      8'h31:   seg_of = 7'b0110000;
      8'h32:   seg_of = 7'b1101101;
      8'h33:   seg_of = 7'b1111001;
      8'h34:   seg_of = 7'b0110011;
      8'h35:   seg_of = 7'b1011011;
      8'h36:   seg_of = 7'b1011111;
      8'h37:   seg_of = 7'b1110000;
      8'h38:   seg_of = 7'b1111111;
      8'h39:   seg_of = 7'b1111011;
      8'h58:   seg_of = 7'b0110111;
      8'h59:   seg_of = 7'b0111011;
      8'h5A:   seg_of = 7'b1101101;
      8'h2D:   seg_of = 7'b0000001;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // Channel label: X/Y/Z for the first three lines, the channel digit after that.
  function automatic logic [7:0] label_code(input int unsigned ch);
    if (ch < 3) label_code = ASC_X + 8'(ch);
    else        label_code = ASC_0 + 8'(ch % 10);
  endfunction

  // Pixel (lx,ly) inside a w x h cell: is it part of the glyph?
  function automatic logic glyph_hit(input logic [7:0] code, input int unsigned lx,
                                     input int unsigned ly, input int unsigned w,
                                     input int unsigned h);
    int unsigned t;
    logic [6:0]  s;
    logic        up, lft, rgt;
    t   = h / 10;
    s   = seg_of(code);
    up  = (ly < h / 2);
    lft = (lx < t);
    rgt = (lx >= w - t);
    if (code == ASC_COLON)
      return ((ly >= h / 4) && (ly < h / 4 + t)) || ((ly >= 3 * h / 4 - t) && (ly < 3 * h / 4));
    return (s[6] && (ly < t)) ||
           (s[5] && rgt && up) || (s[4] && rgt && !up) ||
           (s[3] && (ly >= h - t)) ||
           (s[2] && lft && !up) || (s[1] && lft && up) ||
           (s[0] && (ly >= h / 2 - t / 2) && (ly < h / 2 + t / 2));
  endfunction

  function automatic logic cell_hit(input logic [7:0] code, input int unsigned cx,
                                    input int unsigned cy, input int unsigned x0,
                                    input int unsigned y0, input int unsigned w,
                                    input int unsigned h);
    if ((cx >= x0) && (cx < x0 + w) && (cy >= y0) && (cy < y0 + h))
      return glyph_hit(code, cx - x0, cy - y0, w, h);
    return 1'b0;
  endfunction

endpackage

// File: rtl/vga_value_display_bin2bcd.sv
// Sequential double-dabble binary->BCD converter: one bit per cycle,
// DATA_W cycles per conversion. Keeps enough internal digits to flag
// values that do not fit in NUM_DIGITS.
module bin2bcd_seq #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [DATA_W-1:0]       i_value,
  output logic                    o_done,
  output logic [NUM_DIGITS*4-1:0] o_bcd,
  output logic                    o_ovf
);

  localparam int unsigned FULL_D = ((DATA_W + 2) / 3 > NUM_DIGITS) ? (DATA_W + 2) / 3 : NUM_DIGITS;
  localparam int unsigned BW     = FULL_D * 4;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_sh;
  logic [BW-1:0]     r_bcd;
  logic [BW-1:0]     w_adj;
  logic [CNT_W-1:0]  r_cnt;

  // Add-3 correction on every digit >= 5 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned d = 0; d < FULL_D; d++)
      if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
  end

  // Load on start, then shift one source bit into the BCD field per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_sh  <= i_value;
      r_bcd <= '0;
      r_cnt <= CNT_W'(DATA_W);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[BW-2:0], r_sh[DATA_W-1]};
      r_sh  <= r_sh << 1;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // High during the final shift cycle, so the result is valid on the next cycle.
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd[NUM_DIGITS*4-1:0];

  generate
    if (FULL_D > NUM_DIGITS) begin : g_ovf
      assign o_ovf = |r_bcd[BW-1:NUM_DIGITS*4];
    end else begin : g_no_ovf
      assign o_ovf = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/vga_value_display.sv
// VGA text overlay showing NUM_CH labelled decimal readouts ("X: 0123").
// Inputs are snapshotted at frame_start, converted channel by channel with
// bin2bcd_seq into shadow registers, then committed to the display in one
// cycle. Optional macro VALUE_DISPLAY_SIGNED_EN: two's complement input
// with a sign cell after the colon.
module vga_value_display
  import vga_disp_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned GLYPH_W    = 60,
  parameter int unsigned GLYPH_H    = 100,
  parameter int unsigned DIGIT_GAP  = 10,
  parameter int unsigned BASE_X     = 50,
  parameter int unsigned BASE_Y     = 50,
  parameter int unsigned LINE_PITCH = 120
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [9:0]               CounterX,
  input  logic [9:0]               CounterY,
  input  logic                     inDisplayArea,
  input  logic                     frame_start,
  output logic [3:0]               VGA_R,
  output logic [3:0]               VGA_G,
  output logic [3:0]               VGA_B,
  output logic                     busy
);

  localparam int unsigned LW   = NUM_DIGITS * 4;
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef VALUE_DISPLAY_SIGNED_EN
  localparam int unsigned SIGN_CELLS = 1;
`else
  localparam int unsigned SIGN_CELLS = 0;
`endif

  disp_state_t              r_state;
  logic [CH_W-1:0]          r_ch;
  logic [NUM_CH*DATA_W-1:0] r_snap;
  logic [NUM_CH*LW-1:0]     r_shadow;
  logic [NUM_CH*LW-1:0]     r_disp;
  logic [11:0]              r_rgb;
  logic [DATA_W-1:0]        w_sample;
  logic [DATA_W-1:0]        w_mag;
  logic                     w_done;
  logic                     w_ovf;
  logic [LW-1:0]            w_bcd;
  logic                     w_hit;
  int unsigned              w_cx;
  int unsigned              w_cy;

  assign w_sample = r_snap[r_ch*DATA_W +: DATA_W];

`ifdef VALUE_DISPLAY_SIGNED_EN
  logic              r_neg;
  logic [NUM_CH-1:0] r_shadow_sign;
  logic [NUM_CH-1:0] r_disp_sign;
  // Most negative value negates to itself, which is the correct unsigned magnitude.
  assign w_mag = w_sample[DATA_W-1] ? (~w_sample + DATA_W'(1)) : w_sample;
`else
  assign w_mag = w_sample;
`endif

  bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (r_state == ST_LOAD),
    .i_value (w_mag),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_ovf   (w_ovf)
  );

  // Conversion sequencer: snapshot, convert each channel, commit all lines at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ch     <= '0;
      r_snap   <= '0;
      r_shadow <= '0;
      r_disp   <= '0;
`ifdef VALUE_DISPLAY_SIGNED_EN
      r_neg         <= 1'b0;
      r_shadow_sign <= '0;
      r_disp_sign   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (frame_start) begin
          r_snap  <= data_in;
          r_ch    <= '0;
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
`ifdef VALUE_DISPLAY_SIGNED_EN
          r_neg <= w_sample[DATA_W-1];
`endif
          r_state <= ST_CONV;
        end
        ST_CONV: if (w_done) r_state <= ST_STORE;
        ST_STORE: begin
          r_shadow[r_ch*LW +: LW] <= w_ovf ? {NUM_DIGITS{4'h9}} : w_bcd;
`ifdef VALUE_DISPLAY_SIGNED_EN
          r_shadow_sign[r_ch] <= r_neg;
`endif
          r_ch    <= r_ch + CH_W'(1);
          r_state <= (r_ch == CH_W'(NUM_CH - 1)) ? ST_COMMIT : ST_LOAD;
        end
        ST_COMMIT: begin
          r_disp <= r_shadow;
`ifdef VALUE_DISPLAY_SIGNED_EN
          r_disp_sign <= r_shadow_sign;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign w_cx = {22'd0, CounterX};
  assign w_cy = {22'd0, CounterY};

  // Glyph hit test over every cell of every line for the current pixel.
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      w_hit |= cell_hit(label_code(ch), w_cx, w_cy, BASE_X, BASE_Y + ch * LINE_PITCH,
                        GLYPH_W, GLYPH_H);
      w_hit |= cell_hit(ASC_COLON, w_cx, w_cy, BASE_X + GLYPH_W, BASE_Y + ch * LINE_PITCH,
                        DIGIT_GAP, GLYPH_H);
`ifdef VALUE_DISPLAY_SIGNED_EN
      if (r_disp_sign[ch])
        w_hit |= cell_hit(ASC_MINUS, w_cx, w_cy, BASE_X + GLYPH_W + DIGIT_GAP,
                          BASE_Y + ch * LINE_PITCH, GLYPH_W, GLYPH_H);
`endif
      for (int unsigned d = 0; d < NUM_DIGITS; d++)
        w_hit |= cell_hit(ASC_0 + {4'd0, r_disp[(ch * NUM_DIGITS + NUM_DIGITS - 1 - d) * 4 +: 4]},
                          w_cx, w_cy,
                          BASE_X + GLYPH_W + DIGIT_GAP + (d + SIGN_CELLS) * (GLYPH_W + DIGIT_GAP),
                          BASE_Y + ch * LINE_PITCH, GLYPH_W, GLYPH_H);
    end
  end

  // Registered pixel colour: black glyph on white inside active video.
  always_ff @(posedge clk) begin
    if (rst)
      r_rgb <= '0;
    else if (inDisplayArea && (w_cx < H_ACTIVE) && (w_cy < V_ACTIVE))
      r_rgb <= w_hit ? 12'h000 : 12'hFFF;
    else
      r_rgb <= '0;
  end

  assign VGA_R = r_rgb[11:8];
  assign VGA_G = r_rgb[7:4];
  assign VGA_B = r_rgb[3:0];

endmodule
